// File: rtl/sobel_gradient_pipe.sv
// Purpose : fully pipelined 3x3 Sobel gradient engine producing a saturated magnitude (L1 or max combine),
//           a thresholded edge bit and a running count of delivered results.
// Latency : 4 register stages; a window accepted at edge N is presented from edge N+3 and handed off at edge N+4.
// Backpressure: per-stage valid with collapsing bubbles; o_ready ripples combinationally back from i_ready.
//
// Ports:
//   clk, rst          - rising-edge clock, synchronous active-high reset
//   i_valid/o_ready   - upstream handshake for one 3x3 window (i_window, i_mode, i_thresh)
//   i_window          - nine unsigned PIX_W pixels P0..P8, P0 at the LSBs, row-major
//   i_mode            - 0: |Gx|+|Gy|, 1: max(|Gx|,|Gy|); travels with the window
//   i_thresh          - edge threshold; travels with the window
//   o_valid/i_ready   - downstream handshake for o_mag/o_edge/o_sat
//   o_count           - number of completed output handshakes, wrapping

module sobel_gradient_pipe #(
    parameter int PIX_W   = 8,
    parameter int OUT_W   = 8,
    parameter int COUNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [9*PIX_W-1:0]   i_window,
    input  logic                 i_mode,
    input  logic [OUT_W-1:0]     i_thresh,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [OUT_W-1:0]     o_mag,
    output logic                 o_edge,
    output logic                 o_sat,
    output logic [COUNT_W-1:0]   o_count
);

    // Widths chosen so every stage is exact: differences need one sign bit,
    // the weighted sums span +-4*(2^PIX_W-1), the L1 sum needs one more bit,
    // and the saturation compare is done wide enough to hold 2^OUT_W-1 for
    // every legal OUT_W.
    localparam int DW = PIX_W + 1;
    localparam int GW = PIX_W + 3;
    localparam int AW = PIX_W + 2;
    localparam int CW = PIX_W + 3;
    localparam int XW = PIX_W + 5;
    localparam logic [XW-1:0] MAX_MAG = XW'((1 << OUT_W) - 1);

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic signed [DW-1:0] sdiff(input logic [PIX_W-1:0] a,
                                                   input logic [PIX_W-1:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    function automatic logic signed [GW-1:0] sext(input logic signed [DW-1:0] d);
        return {{2{d[DW-1]}}, d};
    endfunction

    // |g| always fits AW bits because |g| <= 4*(2^PIX_W-1).
    function automatic logic [AW-1:0] absw(input logic signed [GW-1:0] g);
        return AW'(g[GW-1] ? -g : g);
    endfunction

    // ------------------------------------------------------------------
    // Stage state
    // ------------------------------------------------------------------
    logic                    s1_vld_q, s2_vld_q, s3_vld_q, s4_vld_q;

    logic signed [DW-1:0]    s1_diff_q [6];
    logic signed [DW-1:0]    s1_diff_d [6];
    logic                    s1_mode_q;
    logic [OUT_W-1:0]        s1_thr_q;

    logic signed [GW-1:0]    s2_gx_q, s2_gy_q;
    logic signed [GW-1:0]    s2_gx_d, s2_gy_d;
    logic                    s2_mode_q;
    logic [OUT_W-1:0]        s2_thr_q;

    logic [AW-1:0]           s3_ax_q, s3_ay_q;
    logic [AW-1:0]           s3_ax_d, s3_ay_d;
    logic                    s3_mode_q;
    logic [OUT_W-1:0]        s3_thr_q;

    logic [OUT_W-1:0]        s4_mag_q, s4_mag_d;
    logic                    s4_edge_q, s4_edge_d;
    logic                    s4_sat_q, s4_sat_d;

    logic [COUNT_W-1:0]      count_q;

    // ------------------------------------------------------------------
    // Flow control. A stage advances when it holds data and the next stage
    // is empty or itself advancing; a stage loads whenever it is empty or
    // advancing, so bubbles collapse even while the output is stalled.
    // The chain is purely combinational from i_ready back to o_ready.
    // ------------------------------------------------------------------
    logic adv1, adv2, adv3, adv4;
    logic ld1, ld2, ld3, ld4;
    logic accept;

    always_comb begin
        adv4   = s4_vld_q & i_ready;
        adv3   = s3_vld_q & (!s4_vld_q | adv4);
        adv2   = s2_vld_q & (!s3_vld_q | adv3);
        adv1   = s1_vld_q & (!s2_vld_q | adv2);
        ld1    = !s1_vld_q | adv1;
        ld2    = !s2_vld_q | adv2;
        ld3    = !s3_vld_q | adv3;
        ld4    = !s4_vld_q | adv4;
        accept = i_valid & ld1;
    end

    assign o_ready = ld1;

    // ------------------------------------------------------------------
    // S1: six column/row differences
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] px [9];

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            px[k] = i_window[k*PIX_W +: PIX_W];
        end
    end

    always_comb begin
        s1_diff_d[0] = sdiff(px[2], px[0]);   // Gx top
        s1_diff_d[1] = sdiff(px[5], px[3]);   // Gx middle (weighted x2 later)
        s1_diff_d[2] = sdiff(px[8], px[6]);   // Gx bottom
        s1_diff_d[3] = sdiff(px[0], px[6]);   // Gy left
        s1_diff_d[4] = sdiff(px[1], px[7]);   // Gy middle (weighted x2 later)
        s1_diff_d[5] = sdiff(px[2], px[8]);   // Gy right
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_mode_q <= 1'b0;
            s1_thr_q  <= '0;
            for (int k = 0; k < 6; k++) begin
                s1_diff_q[k] <= '0;
            end
        end else if (ld1) begin
            s1_vld_q <= i_valid;
            if (i_valid) begin
                s1_mode_q <= i_mode;
                s1_thr_q  <= i_thresh;
                for (int k = 0; k < 6; k++) begin
                    s1_diff_q[k] <= s1_diff_d[k];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: weighted sums, middle term doubled by a shift
    // ------------------------------------------------------------------
    always_comb begin
        s2_gx_d = sext(s1_diff_q[0]) + (sext(s1_diff_q[1]) <<< 1) + sext(s1_diff_q[2]);
        s2_gy_d = sext(s1_diff_q[3]) + (sext(s1_diff_q[4]) <<< 1) + sext(s1_diff_q[5]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld_q  <= 1'b0;
            s2_gx_q   <= '0;
            s2_gy_q   <= '0;
            s2_mode_q <= 1'b0;
            s2_thr_q  <= '0;
        end else if (ld2) begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_gx_q   <= s2_gx_d;
                s2_gy_q   <= s2_gy_d;
                s2_mode_q <= s1_mode_q;
                s2_thr_q  <= s1_thr_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // S3: absolute values
    // ------------------------------------------------------------------
    always_comb begin
        s3_ax_d = absw(s2_gx_q);
        s3_ay_d = absw(s2_gy_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s3_vld_q  <= 1'b0;
            s3_ax_q   <= '0;
            s3_ay_q   <= '0;
            s3_mode_q <= 1'b0;
            s3_thr_q  <= '0;
        end else if (ld3) begin
            s3_vld_q <= s2_vld_q;
            if (s2_vld_q) begin
                s3_ax_q   <= s3_ax_d;
                s3_ay_q   <= s3_ay_d;
                s3_mode_q <= s2_mode_q;
                s3_thr_q  <= s2_thr_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // S4: combine, saturate, threshold. These registers are the outputs,
    // so they hold still whenever the result is stalled.
    // ------------------------------------------------------------------
    logic [CW-1:0] sum_w;
    logic [AW-1:0] max_w;
    logic [CW-1:0] comb_w;
    logic [XW-1:0] ext_w;

    always_comb begin
        sum_w     = {1'b0, s3_ax_q} + {1'b0, s3_ay_q};
        max_w     = (s3_ax_q >= s3_ay_q) ? s3_ax_q : s3_ay_q;
        comb_w    = s3_mode_q ? {1'b0, max_w} : sum_w;
        ext_w     = XW'(comb_w);
        s4_sat_d  = (ext_w > MAX_MAG);
        s4_mag_d  = s4_sat_d ? {OUT_W{1'b1}} : ext_w[OUT_W-1:0];
        s4_edge_d = (s4_mag_d >= s3_thr_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s4_vld_q  <= 1'b0;
            s4_mag_q  <= '0;
            s4_edge_q <= 1'b0;
            s4_sat_q  <= 1'b0;
        end else if (ld4) begin
            s4_vld_q <= s3_vld_q;
            if (s3_vld_q) begin
                s4_mag_q  <= s4_mag_d;
                s4_edge_q <= s4_edge_d;
                s4_sat_q  <= s4_sat_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Delivered-result counter, wraps naturally at 2^COUNT_W
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (adv4) begin
            count_q <= count_q + COUNT_W'(1);
        end
    end

    assign o_valid = s4_vld_q;
    assign o_mag   = s4_mag_q;
    assign o_edge  = s4_edge_q;
    assign o_sat   = s4_sat_q;
    assign o_count = count_q;

endmodule

// File: tb/tb_sobel_gradient_pipe.sv
// Directed and random-stream bench for sobel_gradient_pipe: a default instance (8/8/16)
// and a narrow instance (10/6/4) for the counter wrap, sharing clock and reset.
// Each scenario task drives its own stimulus and compares inline.

module tb_sobel_gradient_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default instance
    logic        a_vld, a_ordy, a_mode, a_ovld, a_rdy, a_edge, a_sat;
    logic [71:0] a_win;
    logic [7:0]  a_thr, a_mag;
    logic [15:0] a_cnt;

    // Narrow instance
    logic        b_vld, b_ordy, b_mode, b_ovld, b_rdy, b_edge, b_sat;
    logic [89:0] b_win;
    logic [5:0]  b_thr, b_mag;
    logic [3:0]  b_cnt;

    sobel_gradient_pipe #(.PIX_W(8), .OUT_W(8), .COUNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .i_valid(a_vld), .o_ready(a_ordy), .i_window(a_win),
        .i_mode(a_mode), .i_thresh(a_thr), .o_valid(a_ovld), .i_ready(a_rdy),
        .o_mag(a_mag), .o_edge(a_edge), .o_sat(a_sat), .o_count(a_cnt)
    );

    sobel_gradient_pipe #(.PIX_W(10), .OUT_W(6), .COUNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .i_valid(b_vld), .o_ready(b_ordy), .i_window(b_win),
        .i_mode(b_mode), .i_thresh(b_thr), .o_valid(b_ovld), .i_ready(b_rdy),
        .o_mag(b_mag), .o_edge(b_edge), .o_sat(b_sat), .o_count(b_cnt)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int   mag;
        logic edg;
        logic sat;
    } res_t;

    res_t qa[$];
    res_t qb[$];

    // Reference: integer Sobel, combine, clamp
    function automatic int ref_mag(input logic [107:0] w, input int pw, input int ow,
                                   input logic mode, output logic sat);
        int p[9];
        int gx, gy, ax, ay, c, lim;
        for (int k = 0; k < 9; k++) begin
            p[k] = int'((w >> (k*pw)) & ((108'd1 << pw) - 108'd1));
        end
        gx  = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
        gy  = (p[0] + 2*p[1] + p[2]) - (p[6] + 2*p[7] + p[8]);
        ax  = (gx < 0) ? -gx : gx;
        ay  = (gy < 0) ? -gy : gy;
        c   = mode ? ((ax > ay) ? ax : ay) : (ax + ay);
        lim = (1 << ow) - 1;
        sat = (c > lim);
        return sat ? lim : c;
    endfunction

    function automatic logic [71:0] mk8(input int a0, input int a1, input int a2,
                                        input int a3, input int a4, input int a5,
                                        input int a6, input int a7, input int a8);
        int a[9];
        logic [71:0] w;
        a = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
        w = '0;
        for (int k = 0; k < 9; k++) begin
            w[k*8 +: 8] = 8'(a[k]);
        end
        return w;
    endfunction

    // One cycle on the default instance: drive at negedge, observe 1 time unit later.
    task automatic step_a(input logic v, input logic [71:0] w, input logic m, input logic [7:0] t,
                          input logic rdy, output logic acc, output logic outv,
                          output int mag, output logic edg, output logic sat);
        @(negedge clk);
        a_vld = v; a_win = w; a_mode = m; a_thr = t; a_rdy = rdy;
        #1;
        acc  = a_vld & a_ordy;
        outv = a_ovld & a_rdy;
        mag  = int'(a_mag);
        edg  = a_edge;
        sat  = a_sat;
    endtask

    // Send one window into an empty pipe and wait (bounded) for its result.
    task automatic run_one(input logic [71:0] w, input logic m, input logic [7:0] t,
                           output int lat, output int mag, output logic edg, output logic sat);
        logic acc, outv, e1, s1;
        int   m1;
        lat = -1; mag = -1; edg = 1'bx; sat = 1'bx;
        step_a(1'b1, w, m, t, 1'b1, acc, outv, m1, e1, s1);
        if (acc) begin
            for (int k = 1; k <= 10; k++) begin
                step_a(1'b0, '0, 1'b0, 8'd0, 1'b1, acc, outv, m1, e1, s1);
                if (outv) begin
                    lat = k; mag = m1; edg = e1; sat = s1;
                    break;
                end
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1; a_vld = 1'b0; b_vld = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if ({a_ovld, a_mag, a_edge, a_sat, a_cnt} !== 27'd0) begin
            failures++;
            $display("FAIL reset_outputs: got vld=%b mag=%0d edge=%b sat=%b cnt=%0d, want all 0",
                     a_ovld, a_mag, a_edge, a_sat, a_cnt);
        end
        checks++;
        if (b_ovld !== 1'b0 || b_cnt !== 4'd0) begin
            failures++;
            $display("FAIL reset_narrow: got vld=%b cnt=%0d, want 0 0", b_ovld, b_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (a_ordy !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got o_ready=%b, want 1", a_ordy);
        end
    endtask

    task automatic test_vertical_edge();
        int lat, mag; logic edg, sat;
        // Left column 0, right column 10: Gx=40, Gy=0
        run_one(mk8(0, 0, 10, 0, 0, 10, 0, 0, 10), 1'b0, 8'd30, lat, mag, edg, sat);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL vertical_latency: got %0d cycles, want 4", lat);
        end
        checks++;
        if (mag !== 40 || edg !== 1'b1 || sat !== 1'b0) begin
            failures++;
            $display("FAIL vertical_result: got mag=%0d edge=%b sat=%b, want 40 1 0", mag, edg, sat);
        end
    endtask

    task automatic test_back_to_back_modes();
        logic acc0, acc1, acc, outv, edg, sat;
        int   mag, n;
        int   got_mag[2];
        int   got_at[2];
        logic [71:0] w;
        w = mk8(100, 0, 0, 0, 0, 0, 0, 0, 0);
        n = 0;
        step_a(1'b1, w, 1'b0, 8'd0, 1'b1, acc0, outv, mag, edg, sat);
        step_a(1'b1, w, 1'b1, 8'd0, 1'b1, acc1, outv, mag, edg, sat);
        for (int k = 2; k < 10; k++) begin
            step_a(1'b0, '0, 1'b0, 8'd0, 1'b1, acc, outv, mag, edg, sat);
            if (outv && n < 2) begin
                got_mag[n] = mag; got_at[n] = k; n++;
            end
        end
        checks++;
        if (!(acc0 && acc1) || n !== 2) begin
            failures++;
            $display("FAIL corner_count: got accepts=%b%b results=%0d, want 11 2", acc0, acc1, n);
        end else begin
            checks++;
            if (got_mag[0] !== 200 || got_mag[1] !== 100) begin
                failures++;
                $display("FAIL corner_modes: got %0d,%0d, want 200,100", got_mag[0], got_mag[1]);
            end
            checks++;
            if (got_at[0] !== 4 || got_at[1] !== 5) begin
                failures++;
                $display("FAIL corner_timing: got cycles %0d,%0d, want 4,5", got_at[0], got_at[1]);
            end
        end
    endtask

    task automatic test_saturation_and_thresh();
        int lat, mag; logic edg, sat;
        logic [71:0] full;
        full = mk8(0, 0, 255, 0, 0, 255, 0, 0, 255);
        run_one(full, 1'b0, 8'd255, lat, mag, edg, sat);
        checks++;
        if (mag !== 255 || sat !== 1'b1 || edg !== 1'b1) begin
            failures++;
            $display("FAIL fullscale_l1: got mag=%0d sat=%b edge=%b, want 255 1 1", mag, sat, edg);
        end
        run_one(full, 1'b1, 8'd255, lat, mag, edg, sat);
        checks++;
        if (mag !== 255 || sat !== 1'b1 || edg !== 1'b1) begin
            failures++;
            $display("FAIL fullscale_max: got mag=%0d sat=%b edge=%b, want 255 1 1", mag, sat, edg);
        end
        run_one(mk8(77, 77, 77, 77, 77, 77, 77, 77, 77), 1'b0, 8'd0, lat, mag, edg, sat);
        checks++;
        if (mag !== 0 || sat !== 1'b0 || edg !== 1'b1) begin
            failures++;
            $display("FAIL flat_thresh0: got mag=%0d sat=%b edge=%b, want 0 0 1", mag, sat, edg);
        end
        run_one(mk8(77, 77, 77, 77, 77, 77, 77, 77, 77), 1'b0, 8'd1, lat, mag, edg, sat);
        checks++;
        if (mag !== 0 || edg !== 1'b0) begin
            failures++;
            $display("FAIL flat_thresh1: got mag=%0d edge=%b, want 0 0", mag, edg);
        end
    endtask

    task automatic test_stall();
        logic acc, outv, edg, sat;
        int   mag, acc_n, bad_hold;
        res_t e;
        qa.delete();
        acc_n = 0; bad_hold = 0;
        for (int c = 0; c < 10; c++) begin
            step_a(1'b1, mk8(10*(acc_n+1), 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 8'd0, 1'b0,
                   acc, outv, mag, edg, sat);
            if (acc) begin
                e.mag = ref_mag({36'd0, a_win}, 8, 8, 1'b0, e.sat);
                e.edg = 1'b1;
                qa.push_back(e);
                acc_n++;
            end
            if (a_ovld && a_mag !== 8'd20) bad_hold++;
        end
        checks++;
        if (acc_n !== 4 || a_ordy !== 1'b0) begin
            failures++;
            $display("FAIL stall_fill: got accepts=%0d o_ready=%b, want 4 0", acc_n, a_ordy);
        end
        checks++;
        if (a_ovld !== 1'b1 || bad_hold !== 0) begin
            failures++;
            $display("FAIL stall_hold: got o_valid=%b unstable_cycles=%0d, want 1 0", a_ovld, bad_hold);
        end
        for (int c = 0; c < 8; c++) begin
            step_a(c == 0, mk8(50, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 8'd0, 1'b1,
                   acc, outv, mag, edg, sat);
            if (c == 0) begin
                checks++;
                if (a_ordy !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_release_ready: got o_ready=%b, want 1", a_ordy);
                end
            end
            if (acc) begin
                e.mag = ref_mag({36'd0, a_win}, 8, 8, 1'b0, e.sat);
                e.edg = 1'b1;
                qa.push_back(e);
            end
            if (c < 4) begin
                checks++;
                if (outv !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_drain_cycle%0d: got o_valid=%b, want 1", c, outv);
                end
            end
            if (outv) begin
                checks++;
                if (qa.size() == 0) begin
                    failures++;
                    $display("FAIL stall_extra: got unexpected result mag=%0d, want none", mag);
                end else begin
                    e = qa.pop_front();
                    if (mag !== e.mag || sat !== e.sat) begin
                        failures++;
                        $display("FAIL stall_result: got mag=%0d sat=%b, want %0d %b", mag, sat, e.mag, e.sat);
                    end
                end
            end
        end
        checks++;
        if (qa.size() !== 0) begin
            failures++;
            $display("FAIL stall_lost: got %0d results missing, want 0", qa.size());
        end
    endtask

    task automatic test_random_stream();
        logic acc, outv, edg, sat;
        int   mag, sent, got, cyc;
        logic [95:0] r;
        res_t e;
        qa.delete();
        pulse_reset();
        sent = 0; got = 0; cyc = 0;
        while ((sent < 1000 || qa.size() > 0) && cyc < 8000) begin
            r = {$urandom(), $urandom(), $urandom()};
            step_a((sent < 1000) && ($urandom_range(0, 3) != 0), r[71:0], r[72],
                   8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0),
                   acc, outv, mag, edg, sat);
            if (acc) begin
                e.mag = ref_mag({36'd0, a_win}, 8, 8, a_mode, e.sat);
                e.edg = (e.mag >= int'(a_thr));
                qa.push_back(e);
                sent++;
            end
            if (outv) begin
                checks++;
                if (qa.size() == 0) begin
                    failures++;
                    $display("FAIL stream_extra: got unexpected result mag=%0d, want none", mag);
                end else begin
                    e = qa.pop_front();
                    if (mag !== e.mag || edg !== e.edg || sat !== e.sat) begin
                        failures++;
                        $display("FAIL stream_result%0d: got mag=%0d edge=%b sat=%b, want %0d %b %b",
                                 got, mag, edg, sat, e.mag, e.edg, e.sat);
                    end
                end
                got++;
            end
            cyc++;
        end
        a_vld = 1'b0; a_rdy = 1'b1;
        checks++;
        if (sent !== 1000 || got !== 1000) begin
            failures++;
            $display("FAIL stream_totals: got sent=%0d results=%0d, want 1000 1000", sent, got);
        end
        @(negedge clk); #1;
        checks++;
        if (a_cnt !== 16'd1000) begin
            failures++;
            $display("FAIL stream_count: got o_count=%0d, want 1000", a_cnt);
        end
    endtask

    task automatic test_reset_midflight();
        logic acc, outv, edg, sat;
        int   mag, n_acc, n_out, lat;
        n_acc = 0; n_out = 0;
        for (int k = 0; k < 3; k++) begin
            step_a(1'b1, mk8(0, 0, 200, 0, 0, 200, 0, 0, 200), 1'b0, 8'd0, 1'b1,
                   acc, outv, mag, edg, sat);
            if (acc) n_acc++;
        end
        @(negedge clk);
        rst = 1'b1; a_vld = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step_a(1'b0, '0, 1'b0, 8'd0, 1'b1, acc, outv, mag, edg, sat);
            if (outv) n_out++;
        end
        checks++;
        if (n_acc !== 3 || n_out !== 0) begin
            failures++;
            $display("FAIL midreset_flush: got accepts=%0d results=%0d, want 3 0", n_acc, n_out);
        end
        checks++;
        if (a_cnt !== 16'd0) begin
            failures++;
            $display("FAIL midreset_count: got o_count=%0d, want 0", a_cnt);
        end
        // Gx=0, Gy=-(6*2)... P6=P7=P8=3 bottom row: Gy = -(3+6+3) = -12
        run_one(mk8(0, 0, 0, 0, 0, 0, 3, 3, 3), 1'b1, 8'd13, lat, mag, edg, sat);
        checks++;
        if (lat !== 4 || mag !== 12 || edg !== 1'b0) begin
            failures++;
            $display("FAIL midreset_next: got lat=%0d mag=%0d edge=%b, want 4 12 0", lat, mag, edg);
        end
    endtask

    task automatic test_count_wrap();
        int   sent, got, cyc, mag;
        logic [95:0] r;
        logic acc, outv;
        res_t e;
        qb.delete();
        sent = 0; got = 0; cyc = 0;
        while ((sent < 20 || qb.size() > 0) && cyc < 2000) begin
            @(negedge clk);
            r = {$urandom(), $urandom(), $urandom()};
            b_vld  = (sent < 20) && ($urandom_range(0, 2) != 0);
            b_win  = r[89:0];
            b_mode = r[90];
            b_thr  = 6'($urandom_range(0, 63));
            b_rdy  = ($urandom_range(0, 2) != 0);
            #1;
            acc  = b_vld & b_ordy;
            outv = b_ovld & b_rdy;
            if (acc) begin
                e.mag = ref_mag({18'd0, b_win}, 10, 6, b_mode, e.sat);
                e.edg = (e.mag >= int'(b_thr));
                qb.push_back(e);
                sent++;
            end
            if (outv) begin
                if (got == 15) begin
                    checks++;
                    if (b_cnt !== 4'd15) begin
                        failures++;
                        $display("FAIL wrap_before: got o_count=%0d, want 15", b_cnt);
                    end
                end
                mag = int'(b_mag);
                checks++;
                if (qb.size() == 0) begin
                    failures++;
                    $display("FAIL wrap_extra: got unexpected result mag=%0d, want none", mag);
                end else begin
                    e = qb.pop_front();
                    if (mag !== e.mag || b_edge !== e.edg || b_sat !== e.sat) begin
                        failures++;
                        $display("FAIL wrap_result%0d: got mag=%0d edge=%b sat=%b, want %0d %b %b",
                                 got, mag, b_edge, b_sat, e.mag, e.edg, e.sat);
                    end
                end
                got++;
            end
            cyc++;
        end
        b_vld = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (got !== 20 || b_cnt !== 4'd4) begin
            failures++;
            $display("FAIL wrap_count: got results=%0d o_count=%0d, want 20 4", got, b_cnt);
        end
    endtask

    initial begin
        a_vld = 1'b0; a_win = '0; a_mode = 1'b0; a_thr = '0; a_rdy = 1'b1;
        b_vld = 1'b0; b_win = '0; b_mode = 1'b0; b_thr = '0; b_rdy = 1'b1;
        test_reset();
        test_vertical_edge();
        test_back_to_back_modes();
        test_saturation_and_thresh();
        test_stall();
        test_random_stream();
        test_reset_midflight();
        test_count_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
